// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory bus between instruction fetch and load/store.
// MEM has fixed priority, IF is forced in after STARVE_LIMIT MEM wins, and a watchdog aborts hung accesses.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic [31:0] IF_RDATA,
  output logic        IF_DONE,
  output logic        IF_STALL,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_WDATA,
  output logic [31:0] MEM_RDATA,
  output logic        MEM_DONE,
  output logic        MEM_STALL,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [31:0] BUS_WDATA,
  input  logic [31:0] BUS_RDATA,
  input  logic        BUS_ACK,
  output logic        BUS_ERR
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, RESP} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] WDOG_LAST  = 8'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] starve_cnt;
  logic [7:0] wdog;
  logic       grant_mem;
  logic       grant_if;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    if (state == IDLE) begin
      grant_mem = MEM_REQ && !(IF_REQ && (starve_cnt == STARVE_MAX));
      grant_if  = IF_REQ && !grant_mem;
    end
  end

  assign IF_STALL  = IF_REQ  & ~IF_DONE;
  assign MEM_STALL = MEM_REQ & ~MEM_DONE;

  // Counts MEM wins that overtook a pending fetch; any gap in IF_REQ forgives them.
  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RESET_N) begin
      starve_cnt <= '0;
    end else if (!IF_REQ || grant_if) begin
      starve_cnt <= '0;
    end else if (grant_mem && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      wdog      <= '0;
      BUS_REQ   <= 1'b0;
      BUS_WE    <= 1'b0;
      BUS_ADDR  <= '0;
      BUS_WDATA <= '0;
      IF_RDATA  <= '0;
      IF_DONE   <= 1'b0;
      MEM_RDATA <= '0;
      MEM_DONE  <= 1'b0;
      BUS_ERR   <= 1'b0;
    end else begin
      IF_DONE  <= 1'b0;
      MEM_DONE <= 1'b0;
      BUS_ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem) begin
            BUS_REQ   <= 1'b1;
            BUS_WE    <= MEM_WE;
            BUS_ADDR  <= MEM_ADDR;
            BUS_WDATA <= MEM_WDATA;
            wdog      <= '0;
            state     <= BUSY_MEM;
          end else if (grant_if) begin
            BUS_REQ   <= 1'b1;
            BUS_WE    <= 1'b0;
            BUS_ADDR  <= IF_ADDR;
            BUS_WDATA <= '0;
            wdog      <= '0;
            state     <= BUSY_IF;
          end
        end
        BUSY_IF, BUSY_MEM: begin
          wdog <= wdog + 8'd1;
          if (BUS_ACK) begin
            BUS_REQ   <= 1'b0;
            BUS_WE    <= 1'b0;
            BUS_ADDR  <= '0;
            BUS_WDATA <= '0;
            if (state == BUSY_IF) begin
              IF_RDATA <= BUS_RDATA;
              IF_DONE  <= 1'b1;
            end else begin
              MEM_RDATA <= BUS_WE ? 32'd0 : BUS_RDATA;
              MEM_DONE  <= 1'b1;
            end
            state <= RESP;
          end else if (wdog == WDOG_LAST) begin
            // Abort: the requester is released with zero data and an error strobe.
            BUS_REQ <= 1'b0;
            BUS_ERR <= 1'b1;
            if (state == BUSY_IF) begin
              IF_RDATA <= '0;
              IF_DONE  <= 1'b1;
            end else begin
              MEM_RDATA <= '0;
              MEM_DONE  <= 1'b1;
            end
            state <= RESP;
          end
        end
        // One dead cycle so the just-served requester's REQ is not re-granted.
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-ported memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences each access through a grant/wait/response FSM, stalls the losing or waiting stage, and captures read data.
- Fixed MEM-over-IF priority with an anti-starvation limit.
- Bus watchdog: a hung access is aborted so the pipeline is never stuck forever.

Parameters:
- STARVE_LIMIT, 4: consecutive MEM grants allowed while IF_REQ is pending before IF is forced to win (range 1..15).
- TIMEOUT, 64: BUSY-state cycles without BUS_ACK before the access is aborted (range 2..255).

Ports:
- CLK  in  1  sole clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IF_REQ  in  1  fetch request, level; held with IF_ADDR until IF_DONE.
- IF_ADDR  in  32  fetch byte address.
- IF_RDATA  out  32  fetched word, valid while IF_DONE=1.
- IF_DONE  out  1  one-cycle completion pulse.
- IF_STALL  out  1  IF_REQ & ~IF_DONE (combinational).
- MEM_REQ  in  1  load/store request, level; held with MEM_WE/ADDR/WDATA until MEM_DONE.
- MEM_WE  in  1  1=store, 0=load.
- MEM_ADDR  in  32  data byte address.
- MEM_WDATA  in  32  store data.
- MEM_RDATA  out  32  load data, valid while MEM_DONE=1.
- MEM_DONE  out  1  one-cycle completion pulse.
- MEM_STALL  out  1  MEM_REQ & ~MEM_DONE (combinational).
- BUS_REQ  out  1  registered bus request; held until BUS_ACK or timeout.
- BUS_WE  out  1  registered write enable.
- BUS_ADDR  out  32  registered address.
- BUS_WDATA  out  32  registered write data.
- BUS_RDATA  in  32  read data, sampled on the edge where BUS_ACK=1.
- BUS_ACK  in  1  access-complete strobe.
- BUS_ERR  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (RESET_N=0, async):
  - State goes to IDLE.
  - All outputs go to 0: BUS_*, *_RDATA, *_DONE, BUS_ERR.
  - Starvation counter and watchdog counter clear.
  - An in-flight access is dropped with no DONE pulse.
  - STALL outputs still follow their combinational equations.
- FSM states: IDLE, BUSY_IF, BUSY_MEM, RESP.
- IDLE:
  - Grant MEM if MEM_REQ and not (IF_REQ and starve_cnt==STARVE_LIMIT).
  - Otherwise grant IF if IF_REQ.
  - On grant, register the winner's operands onto BUS_*; IF grants drive BUS_WE=0 and BUS_WDATA=0. Set BUS_REQ=1 and move to BUSY_x.
  - Requester operands are not sampled again until the next grant.
- Starvation counter:
  - Increments on each MEM grant while IF_REQ=1, saturating at STARVE_LIMIT.
  - Clears on any IF grant, and on any edge where IF_REQ=0.
- BUSY_x:
  - Watchdog increments each cycle.
  - On the edge with BUS_ACK=1: clear BUS_REQ, BUS_WE, BUS_ADDR and BUS_WDATA; latch BUS_RDATA into x_RDATA (stores latch 0); set x_DONE=1; go to RESP.
  - Watchdog==TIMEOUT-1 with no ACK: clear BUS_REQ, set x_RDATA=0, x_DONE=1, BUS_ERR=1, go to RESP. An ACK in that same cycle wins (normal completion, no error).
- RESP:
  - Exactly one cycle; DONE/ERR pulse is visible here.
  - No grant is made; go to IDLE. This keeps the served requester's still-high REQ from being re-granted.
  - Next edge: DONE/ERR return to 0, x_RDATA holds its value.
- Latency:
  - Request seen in IDLE at cycle 0 → BUS_REQ high in cycle 1.
  - ACK in cycle k ≥ 1 → DONE in cycle k+1 → IDLE in cycle k+2.
  - Best case is one access per 3 cycles.
- BUS_ACK outside the BUSY states is ignored.
- A requester dropping REQ mid-access does not cancel it; the access completes, DONE still pulses, and STALL reads 0.
- Both REQs high in IDLE with starve_cnt<STARVE_LIMIT: MEM wins. IF_STALL stays 1.

Test Plan:
- Single fetch: IF_REQ=1, IF_ADDR=0x0040_0000, ACK after 2 BUSY cycles with RDATA=0x2008_0005 → BUS_ADDR=0x0040_0000, BUS_WE=0; IF_DONE one cycle with IF_RDATA=0x2008_0005 at cycle 4; IF_STALL=1 cycles 0-3.
- Conflict: IF_REQ and MEM_REQ both high in IDLE, MEM_WE=1, ADDR=0x1000_0010, WDATA=0xCAFE_F00D, ACK immediate → MEM served first (BUS_WE=1, data matches, MEM_DONE cycle 2); IF granted at cycle 3.
- Starvation: STARVE_LIMIT=4; MEM_REQ re-asserted each IDLE while IF_REQ held → grant order is 4×MEM then IF.
- Timeout: TIMEOUT=8, grant MEM load, never ACK → BUS_REQ drops after 8 BUSY cycles; MEM_DONE=1, BUS_ERR=1, MEM_RDATA=0 in the same cycle; then IDLE.
- Late/stray ACK: BUS_ACK=1 while IDLE → no DONE, no state change. ACK on the exact timeout cycle → normal completion, BUS_ERR=0.
- Reset mid-access: RESET_N low during BUSY_MEM → BUS_REQ=0 immediately (async), no MEM_DONE. After release with MEM_REQ still 1 → fresh grant; BUS_REQ high 1 cycle later.
